// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI4-Lite bus bundle with master and slave views.
interface axi_lite_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;
   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_data_bridge.sv
// axi_lite_data_bridge: turns single-cycle core data-RAM accesses into stalled AXI4-Lite transactions.
module axi_lite_data_bridge #(
   parameter int         ADDR_WIDTH = 32,
   parameter int         DATA_WIDTH = 32,
   parameter logic [2:0] PROT       = 3'b000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ram_ce_i,
   input  logic                    ram_write_en_i,
   input  logic [ADDR_WIDTH-1:0]   ram_addr_i,
   input  logic [DATA_WIDTH-1:0]   ram_write_data_i,
   input  logic [DATA_WIDTH/8-1:0] ram_sel_i,
   output logic [DATA_WIDTH-1:0]   ram_read_data_o,
   output logic                    stall_o,
   output logic                    err_o,
   axi_lite_if.master              m
);
   typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;
   state_t                  state, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH/8-1:0] sel_q;
   logic [DATA_WIDTH-1:0]   rd_q;
   logic                    aw_done, w_done, err_q;
   logic                    aw_hs, w_hs;
   assign aw_hs = m.awvalid && m.awready;
   assign w_hs  = m.wvalid && m.wready;
   // Valids decode straight from state so an async reset drops them at once.
   assign m.awaddr  = addr_q;
   assign m.awprot  = PROT;
   assign m.awvalid = state == WADDR && !aw_done;
   assign m.wdata   = wdata_q;
   assign m.wstrb   = sel_q;
   assign m.wvalid  = state == WADDR && !w_done;
   assign m.bready  = state == WRESP;
   assign m.araddr  = addr_q;
   assign m.arprot  = PROT;
   assign m.arvalid = state == RADDR;
   assign m.rready  = state == RDATA;
   assign stall_o         = state == IDLE ? ram_ce_i : state != DONE;
   assign err_o           = state == DONE && err_q;
   assign ram_read_data_o = rd_q;
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = !ram_ce_i ? IDLE : ram_write_en_i ? WADDR : RADDR;
         WADDR:   state_d = (aw_done || aw_hs) && (w_done || w_hs) ? WRESP : WADDR;
         WRESP:   state_d = m.bvalid ? DONE : WRESP;
         RADDR:   state_d = m.arready ? RDATA : RADDR;
         RDATA:   state_d = m.rvalid ? DONE : RDATA;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         sel_q   <= '0;
         rd_q    <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state <= state_d;
         if (state == IDLE && ram_ce_i) begin
            addr_q  <= ram_addr_i;
            wdata_q <= ram_write_data_i;
            sel_q   <= ram_sel_i;
         end
         aw_done <= state == WADDR && state_d == WADDR && (aw_done || aw_hs);
         w_done  <= state == WADDR && state_d == WADDR && (w_done || w_hs);
         if (state == WRESP && m.bvalid)
            err_q <= m.bresp != 2'b00;
         if (state == RDATA && m.rvalid) begin
            err_q <= m.rresp != 2'b00;
            rd_q  <= m.rdata;
         end
      end
   end
endmodule

// File: tb/tb_axi_lite_data_bridge.sv
// tb_axi_lite_data_bridge: random and directed accesses against a memory slave and a transaction-level model.
module tb_axi_lite_data_bridge;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ce = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wd = '0, rd;
   logic [3:0]  sel = '0;
   logic        stall, err;
   axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
   axi_lite_data_bridge dut (
      .clk(clk), .rst(rst), .ram_ce_i(ce), .ram_write_en_i(we), .ram_addr_i(addr),
      .ram_write_data_i(wd), .ram_sel_i(sel), .ram_read_data_o(rd), .stall_o(stall),
      .err_o(err), .m(bus)
   );
   always #5 clk = ~clk;
   int checks = 0, errors = 0;
   int aw_wait = 0, w_wait = 0, b_wait = 0, resp_v = 0;
   int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
   logic aw_got, w_got, b_pend, r_pend, mem_ok;
   logic [31:0] aw_a, w_d, r_a;
   logic [3:0]  w_s;
   logic [31:0] mem [256];
   logic [31:0] ref_mem [256];
   logic [31:0] last_rd;
   wire aw_hs = bus.awvalid && bus.awready;
   wire w_hs  = bus.wvalid && bus.wready;
   wire ar_hs = bus.arvalid && bus.arready;
   wire [31:0] cw_a = aw_hs ? bus.awaddr : aw_a;
   wire [31:0] cw_d = w_hs ? bus.wdata : w_d;
   wire [3:0]  cw_s = w_hs ? bus.wstrb : w_s;
   assign bus.awready = aw_cnt >= aw_wait;
   assign bus.wready  = w_cnt >= w_wait;
   assign bus.arready = ar_cnt >= aw_wait;
   assign bus.bvalid  = b_pend && b_cnt >= b_wait;
   assign bus.bresp   = bus.bvalid ? 2'(resp_v) : 2'b00;
   assign bus.rvalid  = r_pend && r_cnt >= b_wait;
   assign bus.rresp   = bus.rvalid ? 2'(resp_v) : 2'b00;
   assign bus.rdata   = mem[r_a[9:2]];
   // Memory slave: byte-strobed writes commit once both AW and W are in.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         if (mem_ok !== 1'b1)
            for (int i = 0; i < 256; i++) mem[i] <= '0;
         mem_ok <= 1'b1;
         {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} <= '0;
         {aw_got, w_got, b_pend, r_pend} <= '0;
         {aw_a, w_d, r_a, w_s} <= '0;
      end else begin
         if (bus.awvalid) aw_cnt <= aw_hs ? 0 : aw_cnt + 1;
         if (bus.wvalid) w_cnt <= w_hs ? 0 : w_cnt + 1;
         if (bus.arvalid) ar_cnt <= ar_hs ? 0 : ar_cnt + 1;
         if (aw_hs) begin aw_a <= bus.awaddr; aw_got <= 1'b1; end
         if (w_hs) begin w_d <= bus.wdata; w_s <= bus.wstrb; w_got <= 1'b1; end
         if ((aw_got || aw_hs) && (w_got || w_hs)) begin
            for (int i = 0; i < 4; i++)
               if (cw_s[i]) mem[cw_a[9:2]][8*i +: 8] <= cw_d[8*i +: 8];
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            b_pend <= 1'b1;
            b_cnt  <= 0;
         end else begin
            if (b_pend && !bus.bvalid) b_cnt <= b_cnt + 1;
            if (bus.bvalid && bus.bready) b_pend <= 1'b0;
         end
         if (ar_hs) begin
            r_a <= bus.araddr; r_pend <= 1'b1; r_cnt <= 0;
         end else begin
            if (r_pend && !bus.rvalid) r_cnt <= r_cnt + 1;
            if (bus.rvalid && bus.rready) r_pend <= 1'b0;
         end
      end
   end
   int n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0, n_bready = 0, n_rready = 0, viol = 0;
   logic paw = 1'b0, pw = 1'b0, par = 1'b0;
   always @(posedge clk) begin
      if (aw_hs) n_aw <= n_aw + 1;
      if (w_hs) n_w <= n_w + 1;
      if (ar_hs) n_ar <= n_ar + 1;
      if (bus.bvalid && bus.bready) n_b <= n_b + 1;
      if (bus.rvalid && bus.rready) n_r <= n_r + 1;
      if (bus.bready) n_bready <= n_bready + 1;
      if (bus.rready) n_rready <= n_rready + 1;
      if (rst && ((paw && !bus.awvalid) || (pw && !bus.wvalid) || (par && !bus.arvalid)))
         viol <= viol + 1;
      paw <= rst && bus.awvalid && !bus.awready;
      pw  <= rst && bus.wvalid && !bus.wready;
      par <= rst && bus.arvalid && !bus.arready;
   end
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int awd, input int wdl, input int bd,
                         input int rs);
      int n, e_n, s_aw, s_w, s_ar, s_b, s_r, s_br, s_rr;
      aw_wait = awd; w_wait = wdl; b_wait = bd; resp_v = rs;
      s_aw = n_aw; s_w = n_w; s_ar = n_ar; s_b = n_b; s_r = n_r; s_br = n_bready; s_rr = n_rready;
      @(negedge clk);
      ce = 1'b1; we = w; addr = a; wd = d; sel = s;
      n = 0;
      #1;
      while (stall && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
      e_n = w ? 3 + (awd > wdl ? awd : wdl) + bd : 3 + awd + bd;
      check("stall_cycles", 64'(n), 64'(e_n));
      check("err_pulse", err, rs != 0);
      if (w) begin
         for (int i = 0; i < 4; i++)
            if (s[i]) ref_mem[a[9:2]][8*i +: 8] = d[8*i +: 8];
      end else
         last_rd = ref_mem[a[9:2]];
      check("read_data", rd, last_rd);
      check("aw_count", 64'(n_aw - s_aw), w);
      check("w_count", 64'(n_w - s_w), w);
      check("b_count", 64'(n_b - s_b), w);
      check("ar_count", 64'(n_ar - s_ar), !w);
      check("r_count", 64'(n_r - s_r), !w);
      check("bready_cycles", 64'(n_bready - s_br), w ? 64'(bd + 1) : 64'd0);
      check("rready_cycles", 64'(n_rready - s_rr), w ? 64'd0 : 64'(bd + 1));
   endtask
   task automatic idle();
      @(negedge clk);
      ce = 1'b0;
      #1;
      check("err_after_done", err, 1'b0);
      check("stall_idle", stall, 1'b0);
   endtask
   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      last_rd = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_stall", stall, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_rdata", rd, 32'h0);
      check("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 5'b0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("idle_quiet", {stall, bus.awvalid, bus.wvalid, bus.arvalid}, 4'b0);
      check("prot", {bus.awprot, bus.arprot}, 6'b0);
      access(1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0); idle();
      access(0, 32'h100, 32'h0, 4'h0, 0, 0, 0, 0); idle();
      access(1, 32'h104, 32'h12345678, 4'hF, 0, 0, 0, 0); idle();
      access(0, 32'h104, 32'h0, 4'h0, 0, 0, 0, 0); idle();
      access(1, 32'h108, 32'hCAFEF00D, 4'hF, 2, 0, 0, 0); idle();
      access(1, 32'h108, 32'h11223344, 4'h0, 0, 2, 1, 0); idle();
      access(0, 32'h108, 32'h0, 4'h0, 0, 0, 0, 0); idle();
      access(1, 32'h10C, 32'hAAAA5555, 4'hF, 0, 0, 0, 0); idle();
      access(0, 32'h10C, 32'h0, 4'h0, 0, 0, 0, 2); idle();
      access(0, 32'h100, 32'h0, 4'h0, 0, 0, 0, 0); idle();
      aw_wait = 5; w_wait = 5;
      @(negedge clk);
      ce = 1'b1; we = 1'b1; addr = 32'h114; wd = 32'h0BADF00D; sel = 4'hF;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("pre_rst_awvalid", bus.awvalid, 1'b1);
      ce = 1'b0;
      rst = 1'b0;
      #1;
      check("async_rst_valids", {bus.awvalid, bus.wvalid, stall}, 3'b0);
      check("async_rst_rdata", rd, 32'h0);
      last_rd = '0;
      @(negedge clk);
      rst = 1'b1;
      access(1, 32'h114, 32'h5A5A0F0F, 4'hF, 0, 0, 0, 0); idle();
      access(0, 32'h114, 32'h0, 4'h0, 0, 0, 0, 0); idle();
      access(1, 32'h118, 32'h76543210, 4'hF, 1, 0, 1, 0);
      access(0, 32'h118, 32'h0, 4'h0, 0, 0, 1, 0);
      idle();
      repeat (60) begin
         logic [31:0] a;
         int rs;
         a = 32'($urandom_range(64, 79)) << 2;
         rs = $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0;
         access($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rs);
         if ($urandom_range(0, 1) == 1) idle();
      end
      idle();
      check("protocol_withdraw", 64'(viol), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
